// File: rtl/params_pkg.sv
// Shared constants for the APB UART transmitter: register map, bit positions and state encodings.
// Pure definitions; no timing or flow-control behaviour of its own.
package params_pkg;

  localparam int APB_AW = 12;
  localparam int APB_DW = 32;

  localparam logic [APB_AW-1:0] REG_DATA   = 12'h000;
  localparam logic [APB_AW-1:0] REG_STATUS = 12'h004;
  localparam logic [APB_AW-1:0] REG_CTRL   = 12'h008;
  localparam logic [APB_AW-1:0] REG_BAUD   = 12'h00C;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_PAR_LSB  = 1;
  localparam int CTRL_TWO_STOP = 3;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } par_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic par_enabled(input par_mode_t m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle between the peripheral-subsystem master and its slaves.
// Slaves drive prdata/pready; no buffering inside the interface itself.
interface apb_if #(
  parameter int AW = params_pkg::APB_AW,
  parameter int DW = params_pkg::APB_DW
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO: rdata is the head word combinationally while !empty; push to pop one cycle.
// Backpressure via full/empty: a push while full or a pop while empty is ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_apb.sv
// APB UART transmitter: TX FIFO feeding a start/data/parity/stop framer with registered tx; pop one cycle after first write.
// Zero-wait-state APB slave; a data write into a full FIFO is dropped and sets sticky overflow.
module uart_tx_apb
  import params_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic clk,
  input  logic reset_n,
  apb_if.slave apb,
  output logic tx,
  output logic irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [LVL_W-1:0]     fifo_level;

  logic                 apb_wr, wr_data, wr_status, wr_ctrl, wr_baud;
  logic                 busy, launch;
  logic                 unused_pwdata;

  logic                 tx_en_q, tx_en_d;
  par_mode_t            par_mode_q, par_mode_d;
  logic                 two_stop_q, two_stop_d;
  logic                 irq_en_q, irq_en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 ovf_q, ovf_d;

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 f_two_stop_q, f_two_stop_d;
  logic [DIV_WIDTH-1:0] f_div_q, f_div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  assign apb_wr    = apb.psel & apb.penable & apb.pwrite;
  assign wr_data   = apb_wr & (apb.paddr == REG_DATA);
  assign wr_status = apb_wr & (apb.paddr == REG_STATUS);
  assign wr_ctrl   = apb_wr & (apb.paddr == REG_CTRL);
  assign wr_baud   = apb_wr & (apb.paddr == REG_BAUD);
  assign fifo_push = wr_data & ~fifo_full;
  assign unused_pwdata = ^apb.pwdata;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (apb.pwdata[DATA_BITS-1:0]),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    tx_en_d    = tx_en_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    irq_en_d   = irq_en_q;
    div_d      = div_q;
    ovf_d      = ovf_q;
    if (wr_ctrl) begin
      tx_en_d    = apb.pwdata[CTRL_TX_EN];
      par_mode_d = par_mode_t'(apb.pwdata[CTRL_PAR_LSB +: 2]);
      two_stop_d = apb.pwdata[CTRL_TWO_STOP];
      irq_en_d   = apb.pwdata[CTRL_IRQ_EN];
    end
    if (wr_baud) begin
      div_d = apb.pwdata[DIV_WIDTH-1:0];
    end
    // A new overflow wins over a simultaneous W1C so the event is never lost.
    if (wr_status && apb.pwdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (wr_data && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  assign bit_end = (cnt_q == f_div_q);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    par_en_d     = par_en_q;
    f_two_stop_d = f_two_stop_q;
    f_div_d      = f_div_q;
    cnt_d        = cnt_q + DIV_WIDTH'(1);
    bit_d        = bit_q;
    tx_d         = tx_q;
    launch       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tx_en_q && !fifo_empty) begin
          launch = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (f_two_stop_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
          end else if (tx_en_q && !fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: snapshot word and config so mid-frame register writes only affect the next frame.
    if (launch) begin
      state_d      = START;
      shift_d      = fifo_rdata;
      par_bit_d    = (^fifo_rdata) ^ (par_mode_q == PAR_ODD);
      par_en_d     = par_enabled(par_mode_q);
      f_two_stop_d = two_stop_q;
      f_div_d      = div_q;
      cnt_d        = '0;
      bit_d        = '0;
      tx_d         = 1'b0;
    end
  end

  assign fifo_pop = launch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_en_q      <= 1'b1;
      par_mode_q   <= PAR_NONE;
      two_stop_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      div_q        <= DIV_WIDTH'(DEFAULT_DIV);
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      par_en_q     <= 1'b0;
      f_two_stop_q <= 1'b0;
      f_div_q      <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
    end else begin
      tx_en_q      <= tx_en_d;
      par_mode_q   <= par_mode_d;
      two_stop_q   <= two_stop_d;
      irq_en_q     <= irq_en_d;
      div_q        <= div_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      par_en_q     <= par_en_d;
      f_two_stop_q <= f_two_stop_d;
      f_div_q      <= f_div_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
    end
  end

  assign busy        = (state_q != IDLE) | ~fifo_empty;
  assign tx          = tx_q;
  assign irq         = irq_en_q & fifo_empty & (state_q == IDLE);
  assign apb.pready  = 1'b1;

  always_comb begin
    apb.prdata = '0;
    case (apb.paddr)
      REG_STATUS: begin
        apb.prdata[STAT_BUSY]               = busy;
        apb.prdata[STAT_FULL]               = fifo_full;
        apb.prdata[STAT_EMPTY]              = fifo_empty;
        apb.prdata[STAT_OVF]                = ovf_q;
        apb.prdata[STAT_LVL_LSB +: LVL_W]   = fifo_level;
      end
      REG_CTRL: begin
        apb.prdata[CTRL_TX_EN]              = tx_en_q;
        apb.prdata[CTRL_PAR_LSB +: 2]       = par_mode_q;
        apb.prdata[CTRL_TWO_STOP]           = two_stop_q;
        apb.prdata[CTRL_IRQ_EN]             = irq_en_q;
      end
      REG_BAUD: begin
        apb.prdata[DIV_WIDTH-1:0]           = div_q;
      end
      default: begin
      end
    endcase
  end

endmodule
